ul_frame_deframer: RTL
======================

# ul_frame_deframer

Surface-side uplink frame extractor sitting directly downstream of the deserializer control stage: consumes the validated 10-bit uplink word stream (`UlDataOut`/`UlDataOutEn`) and the link handshake status. Delimits downhole frames, buffers payload, verifies the checksum, and releases only good frames to the surface data path over a valid/ready interface. Bad, truncated or overrun frames are discarded and counted.

## Interface
- `MAX_LEN`, 64: maximum payload words per frame (2..1023).
- `SOF_WORD`, 10'h3C1: start-of-frame word.
- `TIMEOUT_CYC`, 255: inter-word idle limit inside a frame (used only with timeout feature).
- `CLK_10MHZ` in 1: sole clock; all inputs synchronous to it.
- `Rst` in 1: reset, asynchronous, active-high.
- `UlDataIn` in 10: uplink word from deserializer stage.
- `UlDataInEn` in 1: `UlDataIn` valid this cycle.
- `shakehand_success` in 1: link synchronised; low aborts any frame in progress.
- `OutData` out 10: released payload word.
- `OutValid` out 1: `OutData` valid.
- `OutReady` in 1: consumer accepts word when high with `OutValid`.
- `OutLast` out 1: marks final payload word of a frame.
- `FrameOkCnt` out 16: good frames released, saturating.
- `ErrCnt` out 16: all discarded frames, saturating.
- `ErrPulse` out 1: one-cycle pulse per discarded frame.

## Operation
- Frame format: `SOF_WORD`, LEN (1..`MAX_LEN`), LEN payload words, CHK. CHK = (LEN + sum of payload) mod 1024.
- Words consumed only when `UlDataInEn`=1; other cycles ignored.
- States: IDLE, LEN, PAYLOAD, CHK, DRAIN.
- IDLE: on `SOF_WORD` and buffer free -> LEN. `SOF_WORD` while in DRAIN -> overrun: count error, ignore words until next `SOF_WORD` seen with buffer free. Non-SOF words ignored.
- LEN: LEN=0 or >`MAX_LEN` -> error, IDLE. Else latch LEN, init sum=LEN, -> PAYLOAD.
- PAYLOAD: write word to buffer at index 0..LEN-1, add to sum mod 1024; after LEN-th word -> CHK. `SOF_WORD` inside payload is data (no escaping).
- CHK: match -> DRAIN, `FrameOkCnt`+1; mismatch -> error, IDLE.
- DRAIN: read buffer in order; advance on `OutValid && OutReady`; `OutLast` with word LEN-1; after its handshake -> IDLE.
- `shakehand_success` low in LEN/PAYLOAD/CHK -> error, IDLE. In DRAIN the frame completes (already verified). In IDLE nothing is counted.
- Counters saturate at 16'hFFFF. `ErrPulse` fires once per discarded frame regardless of cause.

## Timing
- Reset: state IDLE, `OutData`=0, `OutValid`=0, `OutLast`=0, counters 0, `ErrPulse`=0, sum/index 0.
- `OutValid` rises the cycle after the CHK word is accepted; first word present that cycle (registered read, prefetched).
- Throughput in DRAIN: one word per cycle while `OutReady` high; `OutData`/`OutLast` stable while `OutValid` and not `OutReady`.
- `ErrPulse` and counter updates occur the cycle after the offending word/event.
- Reset mid-frame or mid-drain: immediate return to reset values; buffer contents don't care.

## Configuration
- `UL_DEFRAME_TIMEOUT_EN` defined: in LEN/PAYLOAD/CHK, a counter of consecutive cycles without `UlDataInEn` reaching `TIMEOUT_CYC` aborts the frame (error, IDLE); counter clears on every accepted word.
- Not defined: no timeout logic; a stalled frame waits indefinitely (only `shakehand_success` low or reset aborts).

## Structure
- Package `ul_deframe_pkg`: state enum, default `SOF_WORD`, checksum width constant (10), counter width (16).
- Sub-module `ul_frame_buf`: simple dual-port `MAX_LEN` x 10 RAM, one write port (PAYLOAD), one registered read port (DRAIN). Everything else in the top.

## Test plan
- Good frame 3C1,003,001,002,003,009 with `OutReady`=1 -> `OutData` 001,002,003 on consecutive cycles, `OutLast` on 003, `FrameOkCnt`=1, `ErrCnt`=0.
- Same frame with CHK=008 -> no `OutValid`, `ErrPulse` once, `ErrCnt`=1.
- LEN=000 and LEN=`MAX_LEN`+1 -> both rejected, `ErrCnt`=2, following good frame released normally.
- Good frame, `OutReady` held low 5 cycles then toggled -> `OutData`/`OutLast` stable while stalled; 3C1,001,055,056 arriving during DRAIN -> overrun, `ErrCnt`+1, drained frame intact.
- `shakehand_success` dropped after second payload word -> `ErrCnt`+1, IDLE; `Rst` pulse mid-DRAIN -> all outputs to reset values next cycle.
- With `UL_DEFRAME_TIMEOUT_EN`, `TIMEOUT_CYC`=4: 3C1,002,010 then 4 idle cycles -> abort, `ErrCnt`+1; 3 idle cycles then 011,023 -> frame good.

Source files
------------

// File: rtl/ul_deframe_pkg.sv
// Shared types and constants for the uplink frame deframer.
// Holds the FSM state encoding, default SOF word and datapath/counter widths.
package ul_deframe_pkg;

  localparam int unsigned CHK_W = 10;
  localparam int unsigned CNT_W = 16;

  localparam logic [CHK_W-1:0] SOF_WORD_DEFAULT = 10'h3C1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  // Saturating increment for the frame/error counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ul_frame_buf.sv
// Payload buffer: simple dual-port RAM, one write port and one registered read port.
// The read register resets to zero because it drives the released data output directly.
module ul_frame_buf
  import ul_deframe_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [CHK_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [CHK_W-1:0] rd_data
);

  logic [CHK_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ul_frame_deframer.sv
// Uplink frame deframer: delimits SOF/LEN/payload/CHK frames, verifies checksum, releases good frames.
// Optional inter-word idle timeout is built when UL_DEFRAME_TIMEOUT_EN is defined.
module ul_frame_deframer
  import ul_deframe_pkg::*;
#(
  parameter int unsigned      MAX_LEN     = 64,
  parameter logic [CHK_W-1:0] SOF_WORD    = SOF_WORD_DEFAULT,
  parameter int unsigned      TIMEOUT_CYC = 255
) (
  input  logic             CLK_10MHZ,
  input  logic             Rst,
  input  logic [CHK_W-1:0] UlDataIn,
  input  logic             UlDataInEn,
  input  logic             shakehand_success,
  output logic [CHK_W-1:0] OutData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             OutLast,
  output logic [CNT_W-1:0] FrameOkCnt,
  output logic [CNT_W-1:0] ErrCnt,
  output logic             ErrPulse
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e           state_q, state_d;
  logic [CHK_W-1:0] len_q, len_d;
  logic [CHK_W-1:0] sum_q, sum_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             ovr_q, ovr_d;
  logic             valid_d, last_d;
  logic             err_c, ok_c;
  logic             wr_en, rd_en;
  logic [AW-1:0]    rd_addr;
  logic             sof_c, in_frame_c, timeout_c, abort_c;

  assign sof_c      = UlDataInEn && (UlDataIn == SOF_WORD);
  assign in_frame_c = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  assign abort_c    = in_frame_c && (!shakehand_success || timeout_c);

`ifdef UL_DEFRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] idle_q, idle_d;

  // Consecutive idle cycles inside a frame; aborts on the TIMEOUT_CYC-th one.
  always_comb begin
    idle_d    = '0;
    timeout_c = 1'b0;
    if (in_frame_c && !UlDataInEn) begin
      if (idle_q == TW'(TIMEOUT_CYC - 1)) timeout_c = 1'b1;
      else                                 idle_d    = idle_q + TW'(1);
    end
  end

  always_ff @(posedge CLK_10MHZ or posedge Rst) begin
    if (Rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  logic unused_timeout;
  assign timeout_c      = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT_CYC);
`endif

  ul_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (CLK_10MHZ),
    .rst     (Rst),
    .wr_en   (wr_en),
    .wr_addr (idx_q),
    .wr_data (UlDataIn),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (OutData)
  );

  always_ff @(posedge CLK_10MHZ or posedge Rst) begin
    if (Rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, datapath and buffer control.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q;
    valid_d = OutValid;
    last_d  = OutLast;
    err_c   = 1'b0;
    ok_c    = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    if (abort_c) begin
      err_c   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ovr_d = 1'b0;
          if (sof_c && shakehand_success) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (UlDataInEn) begin
            if (UlDataIn == '0 || UlDataIn > CHK_W'(MAX_LEN)) begin
              err_c   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              len_d   = UlDataIn;
              sum_d   = UlDataIn;
              idx_d   = '0;
              state_d = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (UlDataInEn) begin
            wr_en = 1'b1;
            sum_d = sum_q + UlDataIn;
            if (idx_q == AW'(len_q - CHK_W'(1))) state_d = ST_CHK;
            else                                  idx_d   = idx_q + AW'(1);
          end
        end
        ST_CHK: begin
          if (UlDataInEn) begin
            if (UlDataIn == sum_q) begin
              // Prefetch word 0 so it is on OutData when OutValid rises.
              ok_c    = 1'b1;
              rd_en   = 1'b1;
              rd_addr = '0;
              idx_d   = '0;
              valid_d = 1'b1;
              last_d  = (len_q == CHK_W'(1));
              state_d = ST_DRAIN;
            end else begin
              err_c   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          // A new frame cannot be buffered yet: discard it once.
          if (sof_c && !ovr_q) begin
            err_c = 1'b1;
            ovr_d = 1'b1;
          end
          if (OutValid && OutReady) begin
            if (OutLast) begin
              valid_d = 1'b0;
              last_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              idx_d   = idx_q + AW'(1);
              rd_en   = 1'b1;
              rd_addr = idx_q + AW'(1);
              last_d  = ((idx_q + AW'(1)) == AW'(len_q - CHK_W'(1)));
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_10MHZ or posedge Rst) begin
    if (Rst) begin
      len_q      <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      ovr_q      <= 1'b0;
      OutValid   <= 1'b0;
      OutLast    <= 1'b0;
      ErrPulse   <= 1'b0;
      ErrCnt     <= '0;
      FrameOkCnt <= '0;
    end else begin
      len_q    <= len_d;
      sum_q    <= sum_d;
      idx_q    <= idx_d;
      ovr_q    <= ovr_d;
      OutValid <= valid_d;
      OutLast  <= last_d;
      ErrPulse <= err_c;
      if (err_c) ErrCnt     <= sat_inc(ErrCnt);
      if (ok_c)  FrameOkCnt <= sat_inc(FrameOkCnt);
    end
  end

endmodule
